// File: rtl/servo_pkg.sv
// Shared servo types: position type, frame constants, parser state enum and checksum helper.
// Frame length and the CHK state depend on SERVO_CMD_CHECKSUM_EN.
package servo_pkg;

   typedef logic [9:0] pos_t;

   localparam pos_t       POS_CENTER    = 10'd512;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

`ifdef SERVO_CMD_CHECKSUM_EN
   localparam int FRAME_LEN = 6;
   typedef enum logic [2:0] {S_HUNT, S_XH, S_XL, S_YH, S_YL, S_CHK} servo_state_e;
`else
   localparam int FRAME_LEN = 5;
   typedef enum logic [2:0] {S_HUNT, S_XH, S_XL, S_YH, S_YL} servo_state_e;
`endif

   // XOR of the four payload bytes as they appear on the wire
   function automatic logic [7:0] frame_chk(input pos_t x, input pos_t y);
      return {6'b0, x[9:8]} ^ x[7:0] ^ {6'b0, y[9:8]} ^ y[7:0];
   endfunction

endpackage

// File: rtl/servo_cmd_decoder_if.sv
// Byte-stream input and servo position outputs of the command decoder.
// rx_valid is a one-cycle strobe carrying one byte in rx_data; there is no ready, the decoder always accepts.
interface servo_cmd_decoder_if;
   import servo_pkg::*;

   logic [7:0] rx_data;
   logic       rx_valid;
   pos_t       pos_x;
   pos_t       pos_y;
   logic       pos_valid;
   logic       frame_err;
   logic       timeout;

   modport master (output rx_data, rx_valid,
                   input  pos_x, pos_y, pos_valid, frame_err, timeout);

   modport slave  (input  rx_data, rx_valid,
                   output pos_x, pos_y, pos_valid, frame_err, timeout);

endinterface

// File: rtl/servo_watchdog.sv
// Saturating watchdog: counts every cycle up to TIMEOUT_CYCLES-1, cleared by clr_i.
// expired_o is high while the count sits at its limit.
module servo_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic expired_o
);

   localparam int unsigned   CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/servo_cmd_decoder.sv
// Parses SYNC/XH/XL/YH/YL[/CHK] byte frames into registered X/Y servo positions with a watchdog fallback.
// Define SERVO_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module servo_cmd_decoder
   import servo_pkg::*;
#(
   parameter pos_t        CENTER         = POS_CENTER,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   servo_cmd_decoder_if.slave   bus,
   output servo_state_e         state_o
);

   servo_state_e state_q;
   pos_t         x_q;
   logic [1:0]   y_hi_q;
`ifdef SERVO_CMD_CHECKSUM_EN
   logic [7:0]   y_lo_q;
`endif
   pos_t         pos_x_q, pos_y_q;
   logic         pos_valid_q, frame_err_q, timeout_q;

   logic         hdr_bad, accept, reject, wd_expired;
   pos_t         y_new;

   always_comb begin
      hdr_bad = bus.rx_valid && ((state_q == S_XH) || (state_q == S_YH))
                && (bus.rx_data[7:2] != 6'b0);
`ifdef SERVO_CMD_CHECKSUM_EN
      y_new   = {y_hi_q, y_lo_q};
      accept  = bus.rx_valid && (state_q == S_CHK) && (bus.rx_data == frame_chk(x_q, y_new));
      reject  = hdr_bad || (bus.rx_valid && (state_q == S_CHK) && !accept);
`else
      y_new   = {y_hi_q, bus.rx_data};
      accept  = bus.rx_valid && (state_q == S_YL);
      reject  = hdr_bad;
`endif
   end

   servo_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (accept),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HUNT;
         x_q         <= '0;
         y_hi_q      <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
         y_lo_q      <= '0;
`endif
         pos_x_q     <= CENTER;
         pos_y_q     <= CENTER;
         pos_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         pos_valid_q <= accept;
         frame_err_q <= reject;
         // A frame completing on the expiry cycle takes priority over the fallback
         if (accept) begin
            pos_x_q   <= x_q;
            pos_y_q   <= y_new;
            timeout_q <= 1'b0;
         end else if (wd_expired) begin
            pos_x_q   <= CENTER;
            pos_y_q   <= CENTER;
            timeout_q <= 1'b1;
         end
         // Inside a frame SYNC_BYTE is ordinary data; only HUNT looks for it
         if (bus.rx_valid) begin
            unique case (state_q)
               S_HUNT: if (bus.rx_data == SYNC_BYTE) state_q <= S_XH;
               S_XH: begin
                  x_q[9:8] <= bus.rx_data[1:0];
                  state_q  <= hdr_bad ? S_HUNT : S_XL;
               end
               S_XL: begin
                  x_q[7:0] <= bus.rx_data;
                  state_q  <= S_YH;
               end
               S_YH: begin
                  y_hi_q  <= bus.rx_data[1:0];
                  state_q <= hdr_bad ? S_HUNT : S_YL;
               end
`ifdef SERVO_CMD_CHECKSUM_EN
               S_YL: begin
                  y_lo_q  <= bus.rx_data;
                  state_q <= S_CHK;
               end
               S_CHK:   state_q <= S_HUNT;
`else
               S_YL:    state_q <= S_HUNT;
`endif
               default: state_q <= S_HUNT;
            endcase
         end
      end
   end

   assign bus.pos_x     = pos_x_q;
   assign bus.pos_y     = pos_y_q;
   assign bus.pos_valid = pos_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.timeout   = timeout_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// Directed and randomized bench for servo_cmd_decoder against a frame-level reference model.
// Follows SERVO_CMD_CHECKSUM_EN for frame length and checksum byte.
module tb_servo_cmd_decoder;
   import servo_pkg::*;

   localparam int unsigned TO   = 100;
   localparam logic [9:0]  CTR  = 10'd512;
   localparam logic [7:0]  SYNC = 8'hAA;
`ifdef SERVO_CMD_CHECKSUM_EN
   localparam int FLEN = 6;
`else
   localparam int FLEN = 5;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   servo_cmd_decoder_if bus();
   servo_state_e        state_o;

   servo_cmd_decoder #(
      .CENTER         (CTR),
      .TIMEOUT_CYCLES (TO),
      .SYNC_BYTE      (SYNC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state_o)
   );

   int checks   = 0;
   int failures = 0;

   // reference model: bytes of the frame in progress, expected outputs, idle cycle count
   logic [7:0]  frm_q[$];
   logic [7:0]  tx_q[$];
   logic [9:0]  m_x = CTR;
   logic [9:0]  m_y = CTR;
   logic        m_pv = 1'b0;
   logic        m_fe = 1'b0;
   logic        m_to = 1'b0;
   int unsigned m_idle = 0;

   task automatic model_step(input logic v, input logic [7:0] d);
      logic accepted;
      logic chk_ok;
      accepted = 1'b0;
      m_pv = 1'b0;
      m_fe = 1'b0;
      if (rst) begin
         frm_q.delete();
         m_x = CTR; m_y = CTR; m_to = 1'b0; m_idle = 0;
         return;
      end
      if (v) begin
         if (frm_q.size() == 0) begin
            if (d == SYNC) frm_q.push_back(d);
         end else begin
            frm_q.push_back(d);
            if ((frm_q.size() == 2 || frm_q.size() == 4) && d > 8'd3) begin
               m_fe = 1'b1;
               frm_q.delete();
            end else if (frm_q.size() == FLEN) begin
`ifdef SERVO_CMD_CHECKSUM_EN
               chk_ok = ((frm_q[1] ^ frm_q[2] ^ frm_q[3] ^ frm_q[4]) == frm_q[5]);
`else
               chk_ok = 1'b1;
`endif
               if (chk_ok) begin
                  m_x = 10'(int'(frm_q[1]) * 256 + int'(frm_q[2]));
                  m_y = 10'(int'(frm_q[3]) * 256 + int'(frm_q[4]));
                  m_pv = 1'b1; m_to = 1'b0; m_idle = 0;
                  accepted = 1'b1;
               end else begin
                  m_fe = 1'b1;
               end
               frm_q.delete();
            end
         end
      end
      if (!accepted) begin
         if (m_idle == TO - 1) begin
            m_to = 1'b1; m_x = CTR; m_y = CTR;
         end else begin
            m_idle++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver: one clock cycle with the given byte strobe, then compare against the model
   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      bus.rx_valid = v;
      bus.rx_data  = d;
      @(posedge clk);
      model_step(v, d);
      #1;
      check("pos_x",     bus.pos_x,            m_x);
      check("pos_y",     bus.pos_y,            m_y);
      check("pos_valid", {9'b0, bus.pos_valid}, {9'b0, m_pv});
      check("frame_err", {9'b0, bus.frame_err}, {9'b0, m_fe});
      check("timeout",   {9'b0, bus.timeout},   {9'b0, m_to});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   task automatic build_frame(input logic [9:0] x, input logic [9:0] y);
      logic [7:0] xh, xl, yh, yl;
      xh = {6'b0, x[9:8]}; xl = x[7:0];
      yh = {6'b0, y[9:8]}; yl = y[7:0];
      tx_q.delete();
      tx_q.push_back(SYNC);
      tx_q.push_back(xh);
      tx_q.push_back(xl);
      tx_q.push_back(yh);
      tx_q.push_back(yl);
`ifdef SERVO_CMD_CHECKSUM_EN
      tx_q.push_back(xh ^ xl ^ yh ^ yl);
`endif
   endtask

   task automatic send_tx(input int gap_max);
      foreach (tx_q[i]) begin
         repeat ($urandom_range(0, gap_max)) step(1'b0, 8'($urandom));
         step(1'b1, tx_q[i]);
      end
   endtask

   initial begin
      logic [9:0] rx, ry;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // reset and idle
      do_reset();
      repeat (5) step(1'b0, 8'h00);
      check("idle_state", 10'(state_o), 10'(S_HUNT));

      // reference frame 300/600
      build_frame(10'd300, 10'd600);
      send_tx(0);
      check("ref_x", bus.pos_x, 10'd300);
      check("ref_y", bus.pos_y, 10'd600);
      check("ref_pv", {9'b0, bus.pos_valid}, 10'd1);

`ifdef SERVO_CMD_CHECKSUM_EN
      // bad checksum rejected, then a good frame accepted
      tx_q = '{8'hAA, 8'h01, 8'h2C, 8'h02, 8'h58, 8'h00};
      send_tx(0);
      check("badchk_fe", {9'b0, bus.frame_err}, 10'd1);
      check("badchk_x", bus.pos_x, 10'd300);
      build_frame(10'd100, 10'd900);
      send_tx(1);
`endif

      // illegal XH, then resync via 00 AA
      tx_q = '{8'hAA, 8'h04};
      send_tx(0);
      check("badxh_fe", {9'b0, bus.frame_err}, 10'd1);
      check("badxh_state", 10'(state_o), 10'(S_HUNT));
      build_frame(10'd300, 10'd600);
      tx_q.push_front(8'h00);
      send_tx(0);
      check("resync_pv", {9'b0, bus.pos_valid}, 10'd1);

      // SYNC byte value used as payload
      build_frame(10'h0AA, 10'h2AA);
      send_tx(0);
      check("syncdata_y", bus.pos_y, 10'h2AA);

      // randomized mix of good frames, garbage and broken frames
      for (int n = 0; n < 60; n++) begin
         rx = 10'($urandom_range(0, 1023));
         ry = 10'($urandom_range(0, 1023));
         case ($urandom_range(0, 3))
            0: begin build_frame(rx, ry); send_tx(2); end
            1: repeat ($urandom_range(1, 4))
                  step(1'b1, ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
            2: begin
                  build_frame(rx, ry);
                  tx_q[($urandom_range(0, 1) == 0) ? 1 : 3] = 8'($urandom_range(4, 255));
                  send_tx(1);
               end
            default: begin
                  build_frame(rx, ry);
                  tx_q[FLEN-1] = tx_q[FLEN-1] ^ 8'($urandom_range(1, 255));
                  send_tx(1);
               end
         endcase
      end

      // watchdog expiry exactly TO cycles after an accepted frame
      do_reset();
      build_frame(10'd7, 10'd1000);
      send_tx(0);
      repeat (TO - 1) step(1'b0, 8'h00);
      check("wd_before", {9'b0, bus.timeout}, 10'd0);
      step(1'b0, 8'h00);
      check("wd_expired", {9'b0, bus.timeout}, 10'd1);
      check("wd_center_x", bus.pos_x, CTR);
      repeat (5) step(1'b0, 8'h00);
      build_frame(10'd20, 10'd40);
      send_tx(1);
      check("wd_cleared", {9'b0, bus.timeout}, 10'd0);
      check("wd_new_x", bus.pos_x, 10'd20);

      // final byte lands on the expiry cycle: frame wins
      repeat (TO - FLEN) step(1'b0, 8'h00);
      build_frame(10'd333, 10'd444);
      send_tx(0);
      check("race_to", {9'b0, bus.timeout}, 10'd0);
      check("race_y", bus.pos_y, 10'd444);
      repeat (3) step(1'b0, 8'h00);

      // reset between XL and YH discards the partial frame
      build_frame(10'd300, 10'd600);
      tx_q = tx_q[0:2];
      send_tx(0);
      do_reset();
      build_frame(10'd300, 10'd600);
      tx_q = tx_q[3:FLEN-1];
      send_tx(0);
      repeat (3) step(1'b0, 8'h00);
      check("mrst_x", bus.pos_x, CTR);
      check("mrst_state", 10'(state_o), 10'(S_HUNT));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
